// File: rtl/bram_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bram_write_arbiter
//  Purpose  : Owns write port A of the dual-port frame/data bRAM. Shares the
//             port between two valid/ready requesters with round-robin
//             arbitration, and contains a clear engine that fills addresses
//             0..CLEAR_LAST with a single value.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             req0_* / req1_*     - requester handshakes (valid/ready/addr/data)
//             clr_start/clr_value - start a clear with the given fill value
//             clr_busy/clr_done   - clear in progress / final-write pulse
//             mem_addra/dina/wea  - registered drive of bRAM port A
//  Revision : 1.0 - initial release
// ============================================================================
module bram_write_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int CLEAR_LAST = 307199
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  output logic              mem_wea
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST_A = ADDR_W'(CLEAR_LAST);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  state_t              state;
  logic                last_grant;   // index of the requester granted most recently
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   clr_fill;
  logic                arb_open;
  logic                grant0;
  logic                grant1;

  // Arbitration is closed during a clear and on the cycle a clear is
  // requested, so a waiting requester is held off rather than racing it.
  assign arb_open = (state == IDLE) && !clr_start;

  // On a tie, the requester that did not win last time goes first.
  assign grant0 = arb_open && req0_valid && (!req1_valid || last_grant);
  assign grant1 = arb_open && req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      clr_cnt    <= '0;
      clr_fill   <= '0;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
      mem_addra  <= '0;
      mem_dina   <= '0;
      mem_wea    <= 1'b0;
    end else begin
      // Write enable and done are single-cycle unless re-asserted below;
      // address and data deliberately hold their last value.
      mem_wea  <= 1'b0;
      clr_done <= 1'b0;

      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clr_fill <= clr_value;
            clr_busy <= 1'b1;
          end else if (grant0) begin
            mem_addra  <= req0_addr;
            mem_dina   <= req0_data;
            mem_wea    <= 1'b1;
            last_grant <= 1'b0;
          end else if (grant1) begin
            mem_addra  <= req1_addr;
            mem_dina   <= req1_data;
            mem_wea    <= 1'b1;
            last_grant <= 1'b1;
          end
        end

        CLEAR: begin
          // clr_start and clr_value are not looked at here, so a restart
          // request mid-clear has no effect.
          mem_addra <= clr_cnt;
          mem_dina  <= clr_fill;
          mem_wea   <= 1'b1;
          clr_cnt   <= clr_cnt + ADDR_ONE;
          if (clr_cnt == CLR_LAST_A) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
